// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit_if
// Purpose  : Pipeline-side bundle between IF/ID and the branch resolve unit.
// Revision : 1.0  initial release
// ============================================================================
interface branch_resolve_unit_if #(
    parameter int CNT_W = 32
);
    logic [63:0]      IF_PC;
    logic             if_pred_taken;
    logic [63:0]      if_pred_target;
    logic             stall;
    logic [31:0]      ID_INST;
    logic [63:0]      ID_PC;
    logic [63:0]      branch_target;
    logic             zero_flag;

    logic             flush;
    logic             redirect_valid;
    logic [63:0]      redirect_pc;
    logic             upd_valid;
    logic             upd_taken;
    logic [63:0]      upd_pc;
    logic [63:0]      upd_target;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispredict_cnt;

    modport master (
        output IF_PC, if_pred_taken, if_pred_target, stall,
               ID_INST, ID_PC, branch_target, zero_flag,
        input  flush, redirect_valid, redirect_pc,
               upd_valid, upd_taken, upd_pc, upd_target,
               branch_cnt, mispredict_cnt
    );

    modport slave (
        input  IF_PC, if_pred_taken, if_pred_target, stall,
               ID_INST, ID_PC, branch_target, zero_flag,
        output flush, redirect_valid, redirect_pc,
               upd_valid, upd_taken, upd_pc, upd_target,
               branch_cnt, mispredict_cnt
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : Resolves ID-stage beq against the fetch-time prediction, issues
//            flush/redirect and predictor updates, keeps saturating stats.
// Revision : 1.0  initial release
// ============================================================================
module branch_resolve_unit #(
    parameter logic [6:0] BRANCH_OPCODE = 7'b1100011,
    parameter int         CNT_W         = 32
) (
    input  wire                  clk,
    input  wire                  arst_n,
    branch_resolve_unit_if.slave bus
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q;
    logic             id_pred_taken_q;
    logic [63:0]      id_pred_target_q;
    logic             flush_q;
    logic             redirect_valid_q;
    logic [63:0]      redirect_pc_q;
    logic             upd_valid_q;
    logic             upd_taken_q;
    logic [63:0]      upd_pc_q;
    logic [63:0]      upd_target_q;
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] mispredict_cnt_q;

    logic        is_br;
    logic        actual_taken;
    logic        mispredict;
    logic [63:0] correct_pc;

    // The fetch PC and the upper instruction bits carry no resolution information.
    logic unused_inputs;
    assign unused_inputs = ^{bus.IF_PC, bus.ID_INST[31:7]};

    assign is_br        = (bus.ID_INST[6:0] == BRANCH_OPCODE);
    assign actual_taken = is_br & bus.zero_flag;
    assign correct_pc   = actual_taken ? bus.branch_target : (bus.ID_PC + 64'd4);

    always_comb begin
        mispredict = 1'b0;
        if (is_br) begin
            mispredict = (actual_taken != id_pred_taken_q) ||
                         (actual_taken && id_pred_taken_q &&
                          (bus.branch_target != id_pred_target_q));
        end else begin
            // A taken prediction on a non-branch is a stale/aliased BTB hit.
            mispredict = id_pred_taken_q;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q          <= ST_RUN;
            id_pred_taken_q  <= 1'b0;
            id_pred_target_q <= 64'd0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 64'd0;
            upd_valid_q      <= 1'b0;
            upd_taken_q      <= 1'b0;
            upd_pc_q         <= 64'd0;
            upd_target_q     <= 64'd0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            upd_valid_q      <= 1'b0;
            if (!bus.stall) begin
                id_pred_taken_q  <= bus.if_pred_taken;
                id_pred_target_q <= bus.if_pred_target;
                case (state_q)
                    ST_RUN: begin
                        if (mispredict) begin
                            flush_q          <= 1'b1;
                            redirect_valid_q <= 1'b1;
                            redirect_pc_q    <= correct_pc;
                            state_q          <= ST_RECOVER;
                            if (mispredict_cnt_q != CNT_MAX) begin
                                mispredict_cnt_q <= mispredict_cnt_q + CNT_ONE;
                            end
                        end
                        if (is_br) begin
                            upd_valid_q  <= 1'b1;
                            upd_taken_q  <= actual_taken;
                            upd_pc_q     <= bus.ID_PC;
                            upd_target_q <= bus.branch_target;
                            if (branch_cnt_q != CNT_MAX) begin
                                branch_cnt_q <= branch_cnt_q + CNT_ONE;
                            end
                        end
                    end
                    ST_RECOVER: begin
                        state_q <= ST_RUN;
                    end
                    default: begin
                        state_q <= ST_RUN;
                    end
                endcase
            end
        end
    end

    assign bus.flush          = flush_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.upd_valid      = upd_valid_q;
    assign bus.upd_taken      = upd_taken_q;
    assign bus.upd_pc         = upd_pc_q;
    assign bus.upd_target     = upd_target_q;
    assign bus.branch_cnt     = branch_cnt_q;
    assign bus.mispredict_cnt = mispredict_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_unit
// Purpose  : Directed + random check of branch_resolve_unit against a
//            behavioural model; narrow counters make saturation reachable.
// Revision : 1.0  initial release
// ============================================================================
module tb_branch_resolve_unit;

    localparam int          CNT_W = 4;
    localparam int          CMAX  = (1 << CNT_W) - 1;
    localparam logic [31:0] BEQ   = 32'h00b50463;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic clk;
    logic arst_n;

    branch_resolve_unit_if #(.CNT_W(CNT_W)) bus ();

    branch_resolve_unit #(.CNT_W(CNT_W)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Model state: whether the ID slot holds a squashed instruction, the
    // prediction that travelled with it, and what the outputs should show.
    bit          m_recover;
    bit          m_pt;
    logic [63:0] m_ptgt;
    bit          e_flush, e_rv, e_uv, e_ut;
    logic [63:0] e_rpc, e_upc, e_utgt;
    int          m_bcnt, m_mcnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_recover = 0; m_pt = 0; m_ptgt = '0;
        e_flush = 0; e_rv = 0; e_uv = 0; e_ut = 0;
        e_rpc = '0; e_upc = '0; e_utgt = '0;
        m_bcnt = 0; m_mcnt = 0;
    endtask

    task automatic model_eval();
        bit          br, act, mis;
        logic [63:0] corr;
        e_flush = 0; e_rv = 0; e_uv = 0;
        if (!bus.stall) begin
            if (m_recover) begin
                m_recover = 0;
            end else begin
                br   = (bus.ID_INST[6:0] == 7'b1100011);
                act  = br && bus.zero_flag;
                if (br) mis = (act != m_pt) || (act && m_pt && bus.branch_target != m_ptgt);
                else    mis = m_pt;
                corr = act ? bus.branch_target : bus.ID_PC + 64'd4;
                if (mis) begin
                    e_flush = 1; e_rv = 1; e_rpc = corr; m_recover = 1;
                    if (m_mcnt < CMAX) m_mcnt++;
                end
                if (br) begin
                    e_uv = 1; e_ut = act; e_upc = bus.ID_PC; e_utgt = bus.branch_target;
                    if (m_bcnt < CMAX) m_bcnt++;
                end
            end
            m_pt   = bus.if_pred_taken;
            m_ptgt = bus.if_pred_target;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".flush"},          64'(bus.flush),          64'(e_flush));
        chk({tag, ".redirect_valid"}, 64'(bus.redirect_valid), 64'(e_rv));
        chk({tag, ".redirect_pc"},    bus.redirect_pc,         e_rpc);
        chk({tag, ".upd_valid"},      64'(bus.upd_valid),      64'(e_uv));
        chk({tag, ".upd_taken"},      64'(bus.upd_taken),      64'(e_ut));
        chk({tag, ".upd_pc"},         bus.upd_pc,              e_upc);
        chk({tag, ".upd_target"},     bus.upd_target,          e_utgt);
        chk({tag, ".branch_cnt"},     64'(bus.branch_cnt),     64'(m_bcnt));
        chk({tag, ".mispredict_cnt"}, 64'(bus.mispredict_cnt), 64'(m_mcnt));
    endtask

    task automatic drive(input bit pt, input logic [63:0] ptgt, input bit stl,
                         input logic [31:0] inst, input logic [63:0] pc,
                         input logic [63:0] tgt, input bit z);
        bus.IF_PC          = pc + 64'd8;
        bus.if_pred_taken  = pt;
        bus.if_pred_target = ptgt;
        bus.stall          = stl;
        bus.ID_INST        = inst;
        bus.ID_PC          = pc;
        bus.branch_target  = tgt;
        bus.zero_flag      = z;
    endtask

    task automatic step(input string tag);
        model_eval();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        arst_n = 1'b0;
        drive(1, 64'h55, 0, BEQ, 64'h10, 64'h20, 1);
        #2;
        check_all("reset");
        @(negedge clk);
        arst_n = 1'b1;

        // Predicted not-taken beq that is taken.
        drive(0, 64'h0, 0, NOP, 64'h3c, 64'h0, 0);       step("r35_setup");
        drive(0, 64'h0, 0, BEQ, 64'h40, 64'h80, 1);      step("r35");
        chk("r35_rpc", bus.redirect_pc, 64'h80);
        chk("r35_mcnt", 64'(bus.mispredict_cnt), 64'd1);
        chk("r35_bcnt", 64'(bus.branch_cnt), 64'd1);
        drive(0, 64'h0, 0, BEQ, 64'h44, 64'h88, 1);      step("r35_recover");

        // Correct taken prediction.
        drive(1, 64'h80, 0, NOP, 64'h60, 64'h0, 0);      step("r36_setup");
        drive(0, 64'h0, 0, BEQ, 64'h64, 64'h80, 1);      step("r36");
        chk("r36_flush", 64'(bus.flush), 64'd0);
        chk("r36_bcnt", 64'(bus.branch_cnt), 64'd2);

        // Aliased taken prediction on a non-branch, then squashed beq.
        drive(1, 64'h80, 0, NOP, 64'hfc, 64'h0, 0);      step("r37_setup");
        drive(0, 64'h0, 0, NOP, 64'h100, 64'h0, 0);      step("r37");
        chk("r37_rpc", bus.redirect_pc, 64'h104);
        chk("r37_uv", 64'(bus.upd_valid), 64'd0);
        drive(0, 64'h0, 0, BEQ, 64'h104, 64'h200, 1);    step("r37_recover");
        chk("r37_rec_uv", 64'(bus.upd_valid), 64'd0);

        // Direction right, target wrong.
        drive(1, 64'h90, 0, NOP, 64'h70, 64'h0, 0);      step("r38_setup");
        drive(0, 64'h0, 0, BEQ, 64'h74, 64'h80, 1);      step("r38");
        chk("r38_rpc", bus.redirect_pc, 64'h80);
        drive(0, 64'h0, 0, NOP, 64'h78, 64'h0, 0);       step("r38_recover");

        // Mispredict held off by stall.
        drive(0, 64'h0, 0, NOP, 64'ha0, 64'h0, 0);       step("r39_setup");
        for (int i = 0; i < 3; i++) begin
            drive(1, 64'h123, 1, BEQ, 64'ha4, 64'hc0, 1); step("r39_stall");
        end
        drive(0, 64'h0, 0, BEQ, 64'ha4, 64'hc0, 1);      step("r39_release");
        chk("r39_flush", 64'(bus.flush), 64'd1);
        chk("r39_rpc", bus.redirect_pc, 64'hc0);

        // Asynchronous reset in the middle of RECOVER.
        #3;
        arst_n = 1'b0;
        #1;
        model_reset();
        check_all("r40_async");
        @(negedge clk);
        arst_n = 1'b1;
        drive(1, 64'h300, 0, NOP, 64'h200, 64'h0, 0);    step("r40_run");
        drive(0, 64'h0, 0, BEQ, 64'h204, 64'h400, 0);    step("r40_after");

        // Random traffic; the narrow counters saturate along the way.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] inst;
            logic [63:0] pc, tgt, ptgt;
            case ($urandom_range(0, 3))
                0, 1:    inst = BEQ;
                2:       inst = NOP;
                default: inst = $urandom;
            endcase
            pc   = ($urandom_range(0, 7) == 0) ? 64'hffff_ffff_ffff_fffc
                                               : {32'h0, $urandom} & ~64'h3;
            tgt  = ($urandom_range(0, 1) == 0) ? 64'h80 : {$urandom, $urandom};
            ptgt = ($urandom_range(0, 1) == 0) ? 64'h80 : 64'h90;
            drive(1'($urandom), ptgt, ($urandom_range(0, 4) == 0), inst, pc, tgt, 1'($urandom));
            step("rand");
        end
        chk("sat_bcnt", 64'(bus.branch_cnt), 64'(CMAX));
        chk("sat_mcnt", 64'(bus.mispredict_cnt), 64'(CMAX));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
